// File: rtl/async_rx_pkg.sv
// Shared types and limits for the asynchronous bundled-data receive controller.
package async_rx_pkg;

    // Handshake sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACK    = 2'd2
    } rx_state_e;

    // Largest settle delay the counter is sized for.
    localparam int MAX_SETTLE = 255;

    // Counter width able to hold the settle load value; never narrower than one bit.
    function automatic int cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/sync_2ff_rst.sv
// Two-flop synchroniser for a single control bit, cleared to 0 by reset.
module sync_2ff_rst (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Retime the asynchronous bit through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/async_bundle_rx_ctrl.sv
// Receive side of a 4-phase bundled-data link: only req is synchronised; the data
// bus is sampled directly once it has had time to settle, then offered on valid/ready.
module async_bundle_rx_ctrl
    import async_rx_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             async_req,
    input  logic [WIDTH-1:0] async_data,
    output logic             async_ack,
    output logic [WIDTH-1:0] sync_data,
    output logic             sync_valid,
    input  logic             sync_ready,
    output logic             proto_err
);

    // Out-of-range settings are clamped so the counter never needs to wrap.
    localparam int SETTLE_EFF = (SETTLE_CYCLES > MAX_SETTLE) ? MAX_SETTLE :
                                (SETTLE_CYCLES < 0)          ? 0          : SETTLE_CYCLES;
    localparam int CNT_W      = cnt_width(SETTLE_EFF);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF);

    logic             w_req_s;
    rx_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ack;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_perr;

    sync_2ff_rst u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (async_req),
        .o_q   (w_req_s)
    );

    // Handshake FSM plus settle counter, capture register, consumer drain and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_perr  <= 1'b0;
        end else begin
            r_perr <= 1'b0;
            // Drain may happen in any state; capture never coincides because
            // SETTLE is only entered while the output slot is empty.
            if (r_valid && sync_ready) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    // Hold off the producer (no ack) while the previous word is unconsumed.
                    if (w_req_s && !r_valid) begin
                        r_state <= SETTLE;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                SETTLE: begin
                    if (!w_req_s) begin
                        r_state <= IDLE;
                        r_perr  <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_data  <= async_data;
                        r_valid <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ACK: begin
                    // Return to IDLE only once req is seen low, so a held req captures once.
                    if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign async_ack  = r_ack;
    assign sync_data  = r_data;
    assign sync_valid = r_valid;
    assign proto_err  = r_perr;

endmodule
